// File: rtl/scaler_sfft_pipe.sv
// Stochastic-bitstream radix-2 FFT: LOG2N registered butterfly stages plus per-point ones counters.
// Latency LOG2N cycles input-to-oReal/oImg; no backpressure, inputs are consumed every cycle oInReq is high.
module scaler_sfft_pipe #(
  parameter int NUMINPUTS = 8,
  parameter int LOG2N     = 3,
  parameter int STREAMLEN = 4096,
  parameter int CNTW      = 13
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iClr,
  input  logic                      iStart,
  input  logic                      iInv,
  input  logic [NUMINPUTS-1:0]      iReal,
  input  logic [NUMINPUTS-1:0]      iImg,
  input  logic [NUMINPUTS/2-1:0]    iTwRe,
  input  logic [NUMINPUTS/2-1:0]    iTwIm,
  output logic                      oBusy,
  output logic                      oInReq,
  output logic                      oDone,
  output logic [NUMINPUTS-1:0]      oReal,
  output logic [NUMINPUTS-1:0]      oImg,
  output logic [NUMINPUTS*CNTW-1:0] oCntReal,
  output logic [NUMINPUTS*CNTW-1:0] oCntImg
);
  localparam int N    = NUMINPUTS;
  localparam int SCW  = 2 * LOG2N;
  localparam int CYCW = $clog2(STREAMLEN + LOG2N);
  localparam int PW   = LOG2N * N;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CYCW-1:0]   r_cyc;
  logic [SCW-1:0]    r_sc;
  logic              r_inv;
  logic [PW-1:0]     r_pipe_re;
  logic [PW-1:0]     r_pipe_im;
  logic [PW-1:0]     w_in_re;
  logic [PW-1:0]     w_in_im;
  logic [PW-1:0]     w_out_re;
  logic [PW-1:0]     w_out_im;
  logic [N*CNTW-1:0] r_cnt_re;
  logic [N*CNTW-1:0] r_cnt_im;
  logic              w_run;
  logic              w_last;
  logic              w_feed;
  logic              w_cnt_en;
  logic              w_start;

  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cyc == CYCW'(STREAMLEN + LOG2N - 1));
  assign w_feed   = w_run && (r_cyc < CYCW'(STREAMLEN));
  assign w_cnt_en = w_run && (r_cyc >= CYCW'(LOG2N));
  assign w_start  = (r_state == IDLE) && iStart && !iClr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iStart) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (iClr) w_next = IDLE;
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Once the stream is exhausted, zeros flush the last samples through the stages.
  assign w_in_re[N-1:0] = w_feed ? iReal : '0;
  assign w_in_im[N-1:0] = w_feed ? iImg  : '0;

  for (genvar s = 1; s < LOG2N; s++) begin : g_link
    assign w_in_re[s*N +: N] = r_pipe_re[(s-1)*N +: N];
    assign w_in_im[s*N +: N] = r_pipe_im[(s-1)*N +: N];
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int H = 1 << s;
    for (genvar g = 0; g < N/2; g++) begin : g_bfly
      localparam int J  = g % H;
      localparam int P0 = (g / H) * 2 * H + J;
      localparam int P1 = P0 + H;
      localparam int K  = J * N / (2 * H);
      logic w_m, w_d, w_wr, w_wi, w_ar, w_ai, w_br, w_bi, w_tr, w_ti;
      assign w_m  = r_sc[2*s];
      assign w_d  = r_sc[2*s+1];
      assign w_wr = iTwRe[K];
      assign w_wi = iTwIm[K] ^ r_inv;
      assign w_ar = w_in_re[s*N+P0];
      assign w_ai = w_in_im[s*N+P0];
      assign w_br = w_in_re[s*N+P1];
      assign w_bi = w_in_im[s*N+P1];
      // Multiplexed scaled product b*W/2: m picks which partial product is sampled.
      assign w_tr = w_m ? ~(w_br ^ w_wr) : (w_bi ^ w_wi);
      assign w_ti = w_m ? ~(w_br ^ w_wi) : ~(w_bi ^ w_wr);
      assign w_out_re[s*N+P0] = w_d ? w_ar : w_tr;
      assign w_out_re[s*N+P1] = w_d ? w_ar : ~w_tr;
      assign w_out_im[s*N+P0] = w_d ? w_ai : w_ti;
      assign w_out_im[s*N+P1] = w_d ? w_ai : ~w_ti;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_cyc     <= '0;
      r_sc      <= '0;
      r_inv     <= 1'b0;
      r_pipe_re <= '0;
      r_pipe_im <= '0;
      r_cnt_re  <= '0;
      r_cnt_im  <= '0;
    end else if (w_start) begin
      r_cyc     <= '0;
      r_sc      <= '0;
      r_inv     <= iInv;
      r_pipe_re <= '0;
      r_pipe_im <= '0;
      r_cnt_re  <= '0;
      r_cnt_im  <= '0;
    end else if (w_run) begin
      if (!w_last) r_cyc <= r_cyc + CYCW'(1);
      r_sc      <= r_sc + SCW'(1);
      r_pipe_re <= w_out_re;
      r_pipe_im <= w_out_im;
      if (w_cnt_en) begin
        for (int p = 0; p < N; p++) begin
          r_cnt_re[p*CNTW +: CNTW] <= r_cnt_re[p*CNTW +: CNTW] + CNTW'(r_pipe_re[(LOG2N-1)*N + p]);
          r_cnt_im[p*CNTW +: CNTW] <= r_cnt_im[p*CNTW +: CNTW] + CNTW'(r_pipe_im[(LOG2N-1)*N + p]);
        end
      end
    end
  end

  assign oBusy    = w_run;
  assign oInReq   = w_feed;
  assign oDone    = (r_state == DONE);
  assign oReal    = r_pipe_re[(LOG2N-1)*N +: N];
  assign oImg     = r_pipe_im[(LOG2N-1)*N +: N];
  assign oCntReal = r_cnt_re;
  assign oCntImg  = r_cnt_im;

endmodule

// File: tb/tb_scaler_sfft_pipe.sv
// Bench for scaler_sfft_pipe: small N=2 instance with hand-derived counts, N=8 instance vs dataflow model.
module tb_scaler_sfft_pipe;
  localparam int BN = 8, BL = 3, BS = 128, BW = 8, BRUN = BS + BL, HLEN = 144;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        b_rst, b_clr, b_start, b_inv;
  logic [7:0]  b_re, b_im;
  logic [3:0]  b_twre, b_twim;
  logic        b_busy, b_inreq, b_done;
  logic [7:0]  b_ore, b_oim;
  logic [63:0] b_cre, b_cim;

  logic        a_rst, a_clr, a_start, a_inv;
  logic [1:0]  a_re, a_im;
  logic [0:0]  a_twre, a_twim;
  logic        a_busy, a_inreq, a_done;
  logic [1:0]  a_ore, a_oim;
  logic [9:0]  a_cre, a_cim;

  scaler_sfft_pipe #(.NUMINPUTS(8), .LOG2N(3), .STREAMLEN(128), .CNTW(8)) u_b (
    .iClk(clk), .iRst(b_rst), .iClr(b_clr), .iStart(b_start), .iInv(b_inv),
    .iReal(b_re), .iImg(b_im), .iTwRe(b_twre), .iTwIm(b_twim),
    .oBusy(b_busy), .oInReq(b_inreq), .oDone(b_done), .oReal(b_ore), .oImg(b_oim),
    .oCntReal(b_cre), .oCntImg(b_cim));

  scaler_sfft_pipe #(.NUMINPUTS(2), .LOG2N(1), .STREAMLEN(16), .CNTW(5)) u_a (
    .iClk(clk), .iRst(a_rst), .iClr(a_clr), .iStart(a_start), .iInv(a_inv),
    .iReal(a_re), .iImg(a_im), .iTwRe(a_twre), .iTwIm(a_twim),
    .oBusy(a_busy), .oInReq(a_inreq), .oDone(a_done), .oReal(a_ore), .oImg(a_oim),
    .oCntReal(a_cre), .oCntImg(a_cim));

  int checks = 0;
  int errors = 0;

  logic [7:0]  h_re [HLEN];
  logic [7:0]  h_im [HLEN];
  logic [3:0]  h_twre [HLEN];
  logic [3:0]  h_twim [HLEN];

  logic [63:0] e_cre, e_cim;
  logic [7:0]  e_fre, e_fim;

  int          o_busy, o_inreq_err, o_done_cyc, o_done_n;
  logic [63:0] o_cre, o_cim;
  logic [7:0]  o_fre, o_fim;

  task automatic gen_random();
    for (int c = 0; c < HLEN; c++) begin
      h_re[c] = 8'($urandom); h_im[c] = 8'($urandom);
      h_twre[c] = 4'($urandom); h_twim[c] = 4'($urandom);
    end
  endtask

  task automatic gen_zero_alt();
    for (int c = 0; c < HLEN; c++) begin
      h_re[c] = '0; h_im[c] = '0; h_twre[c] = '1;
      h_twim[c] = (c % 2 == 1) ? 4'hF : 4'h0;
    end
  endtask

  // Each sample t travels through stage s during run cycle t+s.
  task automatic model_b(input bit inv);
    bit vr[BN], vi[BN], nr[BN], ni[BN];
    int cr[BN], ci[BN];
    int c, sc, h, k;
    bit m, d, wr, wi, ar, ai, br, bi, tr, ti;
    for (int p = 0; p < BN; p++) begin cr[p] = 0; ci[p] = 0; end
    for (int t = 0; t <= BS; t++) begin
      for (int p = 0; p < BN; p++) begin
        vr[p] = (t < BS) ? h_re[t][p] : 1'b0;
        vi[p] = (t < BS) ? h_im[t][p] : 1'b0;
      end
      for (int s = 0; s < BL; s++) begin
        c = t + s;
        sc = c % (1 << (2 * BL));
        m = ((sc >> (2 * s)) & 1) != 0;
        d = ((sc >> (2 * s + 1)) & 1) != 0;
        h = 1 << s;
        for (int i = 0; i < BN; i += 2 * h) begin
          for (int j = 0; j < h; j++) begin
            k = j * BN / (2 * h);
            wr = h_twre[c][k];
            wi = h_twim[c][k] ^ inv;
            ar = vr[i+j]; ai = vi[i+j]; br = vr[i+j+h]; bi = vi[i+j+h];
            tr = m ? (br == wr) : (bi != wi);
            ti = m ? (br == wi) : (bi == wr);
            nr[i+j] = d ? ar : tr;  nr[i+j+h] = d ? ar : !tr;
            ni[i+j] = d ? ai : ti;  ni[i+j+h] = d ? ai : !ti;
          end
        end
        vr = nr; vi = ni;
      end
      for (int p = 0; p < BN; p++) begin
        if (t < BS) begin cr[p] += int'(vr[p]); ci[p] += int'(vi[p]); end
        else begin e_fre[p] = vr[p]; e_fim[p] = vi[p]; end
      end
    end
    for (int p = 0; p < BN; p++) begin
      e_cre[p*BW +: BW] = 8'(cr[p]);
      e_cim[p*BW +: BW] = 8'(ci[p]);
    end
  endtask

  task automatic drive_b(input int c);
    b_re = h_re[c]; b_im = h_im[c]; b_twre = h_twre[c]; b_twim = h_twim[c];
  endtask

  task automatic run_b(input bit inv);
    b_inv = inv; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    o_busy = 0; o_inreq_err = 0; o_done_cyc = -1; o_done_n = 0;
    for (int c = 0; c < BRUN + 5; c++) begin
      drive_b(c);
      @(negedge clk);
      if (b_busy === 1'b1) o_busy++;
      if (b_inreq !== (c < BS)) o_inreq_err++;
      if (b_done === 1'b1) begin
        o_done_n++;
        if (o_done_cyc < 0) begin
          o_done_cyc = c; o_cre = b_cre; o_cim = b_cim; o_fre = b_ore; o_fim = b_oim;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({b_busy, b_inreq, b_done, b_ore, b_oim, b_cre, b_cim} !== '0) begin
      errors++;
      $display("FAIL reset_b: got busy=%b req=%b done=%b re=%h im=%h cre=%h cim=%h expected all 0",
               b_busy, b_inreq, b_done, b_ore, b_oim, b_cre, b_cim);
    end
    checks++;
    if ({a_busy, a_inreq, a_done, a_ore, a_oim, a_cre, a_cim} !== '0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b done=%b cre=%h cim=%h expected all 0", a_busy, a_done, a_cre, a_cim);
    end
  endtask

  task automatic test_n2_allones();
    int done_c, busy;
    logic [9:0] cre, cim;
    logic [1:0] fre, fim;
    done_c = -1; busy = 0; cre = '0; cim = '0; fre = '0; fim = '0;
    a_re = 2'b11; a_im = 2'b11; a_twre = 1'b1; a_twim = 1'b1; a_inv = 1'b0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_busy === 1'b1) busy++;
      if (a_done === 1'b1 && done_c < 0) begin
        done_c = c; cre = a_cre; cim = a_cim; fre = a_ore; fim = a_oim;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_c != 17) begin errors++; $display("FAIL n2_done_cycle: got %0d expected 17", done_c); end
    checks++;
    if (busy != 17) begin errors++; $display("FAIL n2_busy_cycles: got %0d expected 17", busy); end
    checks++;
    if (cre !== {5'd12, 5'd12}) begin errors++; $display("FAIL n2_cnt_real: got %h expected %h", cre, {5'd12, 5'd12}); end
    checks++;
    if (cim !== {5'd8, 5'd16}) begin errors++; $display("FAIL n2_cnt_imag: got %h expected %h", cim, {5'd8, 5'd16}); end
    checks++;
    if ({fre, fim} !== {2'b01, 2'b10}) begin
      errors++; $display("FAIL n2_final_bits: got re=%b im=%b expected re=01 im=10", fre, fim);
    end
  endtask

  task automatic test_zero_alt();
    gen_zero_alt();
    model_b(1'b0);
    run_b(1'b0);
    checks++;
    if (o_done_cyc != BRUN) begin errors++; $display("FAIL zalt_done_cycle: got %0d expected %0d", o_done_cyc, BRUN); end
    checks++;
    if (o_busy != BS + 3) begin errors++; $display("FAIL zalt_busy_cycles: got %0d expected %0d", o_busy, BS + 3); end
    checks++;
    if (o_inreq_err != 0) begin errors++; $display("FAIL zalt_inreq: got %0d bad cycles expected 0", o_inreq_err); end
    checks++;
    if (o_done_n != 1) begin errors++; $display("FAIL zalt_done_pulses: got %0d expected 1", o_done_n); end
    checks++;
    if (o_cre[7:0] !== e_cre[7:0] || o_cim[7:0] !== e_cim[7:0]) begin
      errors++; $display("FAIL zalt_point0: got re=%0d im=%0d expected re=%0d im=%0d", o_cre[7:0], o_cim[7:0], e_cre[7:0], e_cim[7:0]);
    end
    checks++;
    if (o_cre !== e_cre || o_cim !== e_cim) begin
      errors++; $display("FAIL zalt_counts: got re=%h im=%h expected re=%h im=%h", o_cre, o_cim, e_cre, e_cim);
    end
  endtask

  task automatic test_inv();
    gen_random();
    for (int v = 0; v < 2; v++) begin
      model_b(v[0]);
      run_b(v[0]);
      checks++;
      if (o_cre !== e_cre || o_cim !== e_cim) begin
        errors++; $display("FAIL inv%0d_counts: got re=%h im=%h expected re=%h im=%h", v, o_cre, o_cim, e_cre, e_cim);
      end
      checks++;
      if (o_fre !== e_fre || o_fim !== e_fim) begin
        errors++; $display("FAIL inv%0d_final_bits: got re=%h im=%h expected re=%h im=%h", v, o_fre, o_fim, e_fre, e_fim);
      end
      checks++;
      if (b_cre !== e_cre || b_cim !== e_cim) begin
        errors++; $display("FAIL inv%0d_counts_held: got re=%h im=%h expected re=%h im=%h", v, b_cre, b_cim, e_cre, e_cim);
      end
    end
  endtask

  task automatic test_hold_start();
    int dones, busy132, busy133;
    dones = 0; busy132 = -1; busy133 = -1;
    gen_random();
    b_inv = 1'b0; b_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < BRUN + 3; c++) begin
      drive_b(c);
      @(negedge clk);
      if (b_done === 1'b1 && c <= BRUN + 1) dones++;
      if (c == BRUN + 1) busy132 = int'(b_busy);
      if (c == BRUN + 2) busy133 = int'(b_busy);
      @(posedge clk); #1;
    end
    b_start = 1'b0; b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    checks++;
    if (dones != 1) begin errors++; $display("FAIL hold_done_pulses: got %0d expected 1", dones); end
    checks++;
    if (busy132 != 0 || busy133 != 1) begin
      errors++; $display("FAIL hold_restart: got busy %0d,%0d after done expected 0,1", busy132, busy133);
    end
  endtask

  task automatic test_clr();
    int dones, busy;
    dones = 0; busy = 0;
    gen_random();
    b_inv = 1'b0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 20; c++) begin drive_b(c); @(posedge clk); #1; end
    b_clr = 1'b1; b_start = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0; b_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_busy, b_inreq, b_done, b_ore, b_oim, b_cre, b_cim} !== '0) begin
      errors++; $display("FAIL clr_outputs: got busy=%b cre=%h cim=%h re=%h expected all 0", b_busy, b_cre, b_cim, b_ore);
    end
    for (int c = 0; c < BRUN + 5; c++) begin
      @(negedge clk);
      if (b_done === 1'b1) dones++;
      if (b_busy === 1'b1) busy++;
    end
    @(posedge clk); #1;
    checks++;
    if (dones != 0 || busy != 0) begin errors++; $display("FAIL clr_idle: got done=%0d busy=%0d expected 0,0", dones, busy); end
  endtask

  task automatic test_rst_mid();
    int dones;
    dones = 0;
    gen_random();
    b_inv = 1'b1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 5; c++) begin drive_b(c); @(posedge clk); #1; end
    b_rst = 1'b1; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_busy, b_inreq, b_done, b_ore, b_oim, b_cre, b_cim} !== '0) begin
      errors++; $display("FAIL rst_outputs: got busy=%b req=%b cre=%h re=%h expected all 0", b_busy, b_inreq, b_cre, b_ore);
    end
    @(posedge clk); #1;
    b_rst = 1'b0;
    for (int c = 0; c < BRUN + 5; c++) begin
      @(negedge clk);
      if (b_done === 1'b1) dones++;
    end
    @(posedge clk); #1;
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
    model_b(1'b0);
    run_b(1'b0);
    checks++;
    if (o_cre !== e_cre || o_cim !== e_cim || o_fre !== e_fre || o_fim !== e_fim) begin
      errors++; $display("FAIL rst_rerun: got re=%h im=%h expected re=%h im=%h", o_cre, o_cim, e_cre, e_cim);
    end
  endtask

  initial begin
    b_rst = 1'b1; b_clr = 1'b0; b_start = 1'b0; b_inv = 1'b0;
    b_re = '0; b_im = '0; b_twre = '0; b_twim = '0;
    a_rst = 1'b1; a_clr = 1'b0; a_start = 1'b0; a_inv = 1'b0;
    a_re = '0; a_im = '0; a_twre = '0; a_twim = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    b_rst = 1'b0; a_rst = 1'b0;
    @(posedge clk); #1;
    test_n2_allones();
    test_zero_alt();
    test_inv();
    test_hold_start();
    test_clr();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
